// File: rtl/mem_write_buffer_pkg.sv
// Shared types for the posted-write buffer: CPU word type, queue entry and pmem FSM states.
// Optional store-to-load forwarding is enabled by defining WBUF_FWD_EN.
package rv32i_types;
    typedef logic [31:0] rv32i_word;
endpackage

package wbuf_types;
    import rv32i_types::*;

    localparam int WBUF_DEPTH_DEFAULT = 4;

    typedef struct packed {
        rv32i_word   addr;
        rv32i_word   data;
        logic [3:0]  be;
    } wbuf_entry_t;

    typedef enum logic [1:0] {P_IDLE, P_WRITE, P_READ, P_RESP} pstate_t;

    // Word-granular address compare used by forwarding.
    function automatic logic word_match(input rv32i_word a, input rv32i_word b);
        return a[31:2] == b[31:2];
    endfunction
endpackage

// File: rtl/mem_write_buffer_if.sv
// Request/response memory port shared by the CPU side and the pmem side.
// master issues requests, slave answers them with a 1-cycle resp.
interface mem_write_buffer_if;
    import rv32i_types::*;

    logic       read;
    logic       write;
    logic [3:0] byte_enable;
    rv32i_word  address;
    rv32i_word  wdata;
    logic       resp;
    rv32i_word  rdata;

    modport master (output read, write, byte_enable, address, wdata, input resp, rdata);
    modport slave  (input read, write, byte_enable, address, wdata, output resp, rdata);
endinterface

// File: rtl/mem_write_buffer_fifo.sv
// Store queue for the write buffer: circular storage, head/tail pointers and occupancy count.
// With WBUF_FWD_EN defined it also exposes every entry, a valid mask and the head pointer.
module wbuf_fifo
    import wbuf_types::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEFAULT,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  wbuf_entry_t din_i,
    output wbuf_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
`ifdef WBUF_FWD_EN
    ,
    output wbuf_entry_t      entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o,
    output logic [PW-1:0]    head_ptr_o
`endif
);
    wbuf_entry_t   mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[head_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + 1'b1;
            if (do_pop)  head_q <= head_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef WBUF_FWD_EN
    // A slot is live when its age behind the head is below the count.
    always_comb begin
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++)
            valid_o[i] = {1'b0, PW'(i) - head_q} < count_q;
    end
    assign entries_o  = mem_q;
    assign head_ptr_o = head_q;
`endif
endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the CPU memory port and pmem: stores are acked on enqueue and
// drained in order; loads wait for an empty queue. WBUF_FWD_EN adds store-to-load forwarding.
module mem_write_buffer
    import rv32i_types::*;
    import wbuf_types::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    mem_write_buffer_if.slave  cpu,
    mem_write_buffer_if.master pmem
);
    localparam int PW = $clog2(DEPTH);

    pstate_t     state_q, state_d;
    logic        ack_q, ack_d;
    rv32i_word   rdata_q, rdata_d;
    logic        cpu_resp, push, pop, full, empty;
    logic        fwd_hit, fwd_take;
    rv32i_word   fwd_data;
    wbuf_entry_t head, din;

    assign cpu_resp  = ack_q || (state_q == P_RESP);
    assign cpu.resp  = cpu_resp;
    assign cpu.rdata = rdata_q;

    assign push = cpu.write && !full && !cpu_resp;
    assign din  = '{addr: cpu.address, data: cpu.wdata, be: cpu.byte_enable};

`ifdef WBUF_FWD_EN
    wbuf_entry_t      entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    head_ptr, idx;
    logic             m_found;
    wbuf_entry_t      m_ent;

    // Walk oldest to youngest so the last match left standing is the youngest one.
    always_comb begin
        m_found = 1'b0;
        m_ent   = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PW'(k);
            if (valid[idx] && word_match(entries[idx].addr, cpu.address)) begin
                m_found = 1'b1;
                m_ent   = entries[idx];
            end
        end
    end
    assign fwd_hit  = m_found && (m_ent.be == 4'hF);
    assign fwd_data = m_ent.data;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // Forwarding also works while a drain is in flight, so a stalled pmem never blocks a hit.
    assign fwd_take = fwd_hit && cpu.read && !cpu_resp && (state_q inside {P_IDLE, P_WRITE});
    assign ack_d    = push || fwd_take;

    wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pop_i      (pop),
        .din_i      (din),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty)
`ifdef WBUF_FWD_EN
        ,
        .entries_o  (entries),
        .valid_o    (valid),
        .head_ptr_o (head_ptr)
`endif
    );

    always_comb begin
        state_d          = state_q;
        rdata_d          = rdata_q;
        pop              = 1'b0;
        pmem.read        = 1'b0;
        pmem.write       = 1'b0;
        pmem.byte_enable = '0;
        pmem.address     = '0;
        pmem.wdata       = '0;
        if (fwd_take) rdata_d = fwd_data;
        unique case (state_q)
            P_IDLE: begin
                if (!empty)                     state_d = P_WRITE;
                else if (cpu.read && !cpu_resp) state_d = P_READ;
            end
            P_WRITE: begin
                pmem.write       = 1'b1;
                pmem.address     = head.addr;
                pmem.wdata       = head.data;
                pmem.byte_enable = head.be;
                if (pmem.resp) begin
                    pop     = 1'b1;
                    state_d = P_IDLE;
                end
            end
            P_READ: begin
                pmem.read        = 1'b1;
                pmem.address     = cpu.address;
                pmem.byte_enable = 4'hF;
                if (pmem.resp) begin
                    rdata_d = pmem.rdata;
                    state_d = P_RESP;
                end
            end
            P_RESP:  state_d = P_IDLE;
            default: state_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= P_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_write_buffer.sv
// Scoreboarded bench for mem_write_buffer: expected pmem stores are queued when the CPU issues
// them and checked by the pmem model as they drain. Define WBUF_FWD_EN to cover forwarding.
module tb_mem_write_buffer;
    import rv32i_types::*;
    import wbuf_types::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_write_buffer_if cpu ();
    mem_write_buffer_if pm ();

    mem_write_buffer #(.DEPTH(DEPTH)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .cpu  (cpu),
        .pmem (pm)
    );

    typedef struct packed { logic wr; rv32i_word addr; } op_t;

    int          checks = 0;
    int          errors = 0;
    wbuf_entry_t exp_wr [$];
    op_t         op_log [$];
    rv32i_word   mem [rv32i_word];
    int          lat = 3;
    bit          stall = 1'b0;
    int          n_wr = 0;
    int          n_rd = 0;
    int          wr_at_resp = 0;

    // pmem model: answers after lat cycles unless stalled; checks stores against the scoreboard.
    initial begin : pmem_model
        int          wait_cnt;
        wbuf_entry_t e;
        rv32i_word   w;
        wait_cnt = 0;
        pm.resp  = 1'b0;
        pm.rdata = '0;
        forever begin
            @(negedge clk);
            pm.resp = 1'b0;
            if (rst && !stall && (pm.read || pm.write)) begin
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    wait_cnt = 0;
                    pm.resp  = 1'b1;
                    op_log.push_back('{wr: pm.write, addr: pm.address});
                    if (pm.write) begin
                        n_wr++;
                        checks++;
                        if (exp_wr.size() == 0) begin
                            errors++;
                            $display("FAIL pmem_write unexpected: got addr %h data %h, none expected", pm.address, pm.wdata);
                        end else begin
                            e = exp_wr.pop_front();
                            if (pm.address !== e.addr || pm.wdata !== e.data || pm.byte_enable !== e.be) begin
                                errors++;
                                $display("FAIL pmem_write order: got %h/%h/%h want %h/%h/%h",
                                         pm.address, pm.wdata, pm.byte_enable, e.addr, e.data, e.be);
                            end
                        end
                        w = mem.exists(pm.address) ? mem[pm.address] : '0;
                        for (int b = 0; b < 4; b++)
                            if (pm.byte_enable[b]) w[8*b +: 8] = pm.wdata[8*b +: 8];
                        mem[pm.address] = w;
                    end else begin
                        n_rd++;
                        pm.rdata = mem.exists(pm.address) ? mem[pm.address] : '0;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // n counts rising edges from request to the resp cycle (request held n+1 cycles).
    task automatic cpu_store(input rv32i_word a, input rv32i_word d, input logic [3:0] be, output int n);
        exp_wr.push_back('{addr: a, data: d, be: be});
        cpu.address = a; cpu.wdata = d; cpu.byte_enable = be; cpu.write = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!cpu.resp && n < 100);
        wr_at_resp = n_wr;
        @(posedge clk); #1;
        cpu.write = 1'b0;
    endtask

    task automatic cpu_load(input rv32i_word a, output rv32i_word d, output int n);
        cpu.address = a; cpu.byte_enable = 4'hF; cpu.read = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!cpu.resp && n < 100);
        d = cpu.rdata;
        @(posedge clk); #1;
        cpu.read = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_wr.size() != 0 || pm.write || pm.read) && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (exp_wr.size() != 0) begin
            errors++;
            $display("FAIL %s drain: got %0d stores outstanding, want 0", tag, exp_wr.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({cpu.resp, cpu.rdata, pm.read, pm.write, pm.byte_enable, pm.address, pm.wdata} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got resp %b rdata %h pr %b pw %b", cpu.resp, cpu.rdata, pm.read, pm.write);
        end
        checks++;
        if (u_dut.u_fifo.count_q !== 0) begin
            errors++;
            $display("FAIL reset count: got %0d want 0", u_dut.u_fifo.count_q);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_store();
        int n, base;
        bit seen = 1'b0;
        lat = 3; stall = 1'b0; base = n_wr;
        cpu_store(32'h100, 32'hDEADBEEF, 4'hF, n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL store_ack latency: got %0d want 1", n); end
        for (int k = 0; k < 2 && !seen; k++) begin
            @(negedge clk);
            if (pm.write && pm.address == 32'h100) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL store_issue: got no pmem_write to 100 want within 2 cycles"); end
        @(posedge clk); #1;
        wait_drain("store");
        checks++;
        if (n_wr != base + 1) begin errors++; $display("FAIL store_pops: got %0d want %0d", n_wr - base, 1); end
    endtask

    task automatic test_back_to_back();
        int n, n5;
        bit early = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_store(rv32i_word'(i * 4), 32'hB0B0_0000 + rv32i_word'(i), 4'hF, n);
            checks++;
            if (n != 1) begin errors++; $display("FAIL b2b_ack[%0d]: got %0d want 1", i, n); end
        end
        fork
            cpu_store(32'h10, 32'hB0B0_0004, 4'hF, n5);
            begin
                repeat (8) begin @(negedge clk); if (cpu.resp) early = 1'b1; end
                stall = 1'b0;
            end
        join
        checks++;
        if (early) begin errors++; $display("FAIL b2b_full: got cpu_resp while full, want none"); end
        checks++;
        if (n5 >= 100 || wr_at_resp < 1) begin
            errors++;
            $display("FAIL b2b_5th: got latency %0d after %0d drains, want resp after >=1 drain", n5, wr_at_resp);
        end
        wait_drain("b2b");
    endtask

    task automatic test_store_then_load();
        int n;
        rv32i_word d;
        op_log.delete();
        cpu_store(32'h200, 32'h11223344, 4'hF, n);
`ifdef WBUF_FWD_EN
        wait_drain("st_ld");
`endif
        cpu_load(32'h200, d, n);
        checks++;
        if (d !== 32'h11223344) begin errors++; $display("FAIL st_ld data: got %h want 11223344", d); end
        checks++;
        if (op_log.size() != 2 || op_log[0] !== '{1'b1, 32'h200} || op_log[1] !== '{1'b0, 32'h200}) begin
            errors++;
            $display("FAIL st_ld order: got %0d ops, want write 200 then read 200", op_log.size());
        end
        cpu_load(32'h200, d, n);
        checks++;
        if (n != lat + 1 || d !== 32'h11223344) begin
            errors++;
            $display("FAIL load_latency: got %0d/%h want %0d/11223344", n, d, lat + 1);
        end
    endtask

    task automatic test_forward();
        int n, rd0;
        rv32i_word d;
        bit early = 1'b0;
        stall = 1'b1; rd0 = n_rd;
        cpu_store(32'h300, 32'hCAFEF00D, 4'hF, n);
`ifdef WBUF_FWD_EN
        cpu_load(32'h300, d, n);
        checks++;
        if (d !== 32'hCAFEF00D || n != 1) begin
            errors++;
            $display("FAIL fwd_full: got %h in %0d want cafef00d in 1", d, n);
        end
        checks++;
        if (n_rd != rd0) begin errors++; $display("FAIL fwd_no_pmem: got %0d reads want 0", n_rd - rd0); end
`endif
        cpu_store(32'h300, 32'h77885566, 4'h3, n);
        fork
            cpu_load(32'h300, d, n);
            begin
                repeat (8) begin @(negedge clk); if (cpu.resp) early = 1'b1; end
                stall = 1'b0;
            end
        join
        checks++;
        if (early) begin errors++; $display("FAIL partial_wait: got cpu_resp before drain want none"); end
        checks++;
        if (d !== 32'hCAFE5566 || n_rd != rd0 + 1) begin
            errors++;
            $display("FAIL partial_data: got %h reads %0d want cafe5566 reads 1", d, n_rd - rd0);
        end
        wait_drain("fwd");
    endtask

    task automatic test_reset_midwrite();
        int n, base;
        bit seen = 1'b0;
        rv32i_word d;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) cpu_store(32'h400 + rv32i_word'(4 * i), 32'h4040_0000 + rv32i_word'(i), 4'hF, n);
        for (int k = 0; k < 5 && !seen; k++) begin @(negedge clk); seen = pm.write; end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu.resp, cpu.rdata, pm.read, pm.write, pm.byte_enable, pm.address, pm.wdata} !== '0
            || u_dut.u_fifo.count_q !== 0) begin
            errors++;
            $display("FAIL midreset: got pw %b addr %h rdata %h count %0d want all 0",
                     pm.write, pm.address, cpu.rdata, u_dut.u_fifo.count_q);
        end
        exp_wr.delete();
        stall = 1'b0; base = n_wr;
        mem[32'h500] = 32'hA5A50005;
        @(posedge clk); #1;
        cpu.address = 32'h500; cpu.read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (!pm.read || pm.address !== 32'h500) begin
            errors++;
            $display("FAIL midreset_load: got pr %b addr %h want 1/500", pm.read, pm.address);
        end
        n = 0;
        while (!cpu.resp && n < 100) begin @(negedge clk); n++; end
        d = cpu.rdata;
        @(posedge clk); #1;
        cpu.read = 1'b0;
        checks++;
        if (d !== 32'hA5A50005 || n_wr != base) begin
            errors++;
            $display("FAIL midreset_data: got %h writes %0d want a5a50005 writes 0", d, n_wr - base);
        end
    endtask

    task automatic test_held_write();
        int n, base, c0;
        stall = 1'b1; base = n_wr;
        c0 = int'(u_dut.u_fifo.count_q);
        cpu_store(32'h600, 32'h00600600, 4'hF, n);
        repeat (3) @(negedge clk);
        checks++;
        if (int'(u_dut.u_fifo.count_q) != c0 + 1) begin
            errors++;
            $display("FAIL held_write count: got %0d want %0d", u_dut.u_fifo.count_q, c0 + 1);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        wait_drain("held");
        checks++;
        if (n_wr != base + 1) begin errors++; $display("FAIL held_write drains: got %0d want 1", n_wr - base); end
    endtask

    initial begin
        cpu.read = 1'b0; cpu.write = 1'b0; cpu.address = '0; cpu.wdata = '0; cpu.byte_enable = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_store();
        test_back_to_back();
        test_store_then_load();
        test_forward();
        test_reset_midwrite();
        test_held_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
